// File: rtl/char_buffer_arbiter_pkg.sv
// Shared constants, glyph codes and arbiter state encoding for the text character buffer.
package char_buffer_pkg;

    localparam int TEXT_COLS = 80;
    localparam int TEXT_ROWS = 60;
    localparam int ADDR_W    = 13;
    localparam int CODE_W    = 6;

    localparam logic [CODE_W-1:0] GLYPH_BLANK       = 6'h00;
    localparam logic [CODE_W-1:0] GLYPH_A           = 6'h27;
    localparam logic [CODE_W-1:0] GLYPH_ARROW_UP    = 6'h28;
    localparam logic [CODE_W-1:0] GLYPH_ARROW_DOWN  = 6'h29;
    localparam logic [CODE_W-1:0] GLYPH_ARROW_LEFT  = 6'h2A;
    localparam logic [CODE_W-1:0] GLYPH_ARROW_RIGHT = 6'h2B;
    localparam logic [CODE_W-1:0] MAX_CODE          = GLYPH_ARROW_RIGHT;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    // A glyph code is usable only up to the last defined glyph.
    function automatic logic code_valid(input logic [CODE_W-1:0] code);
        return (code <= MAX_CODE);
    endfunction

endpackage

// File: rtl/char_buffer_arbiter_if.sv
// Bundle of requester, RAM write and blink signals around the character buffer arbiter.
interface char_buffer_arbiter_if;
    import char_buffer_pkg::*;

    logic              req0;
    logic              wr0;
    logic [ADDR_W-1:0] addr0;
    logic [CODE_W-1:0] code0;
    logic              gnt0;
    logic              req1;
    logic              wr1;
    logic [ADDR_W-1:0] addr1;
    logic [CODE_W-1:0] code1;
    logic              gnt1;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [CODE_W-1:0] ram_code;
    logic              code_err;
    logic              frame_tick;
    logic              alarm_on;
    logic              bit_alarma;

    // Arbiter side.
    modport slave (
        input  req0, wr0, addr0, code0, req1, wr1, addr1, code1, frame_tick, alarm_on,
        output gnt0, gnt1, ram_we, ram_addr, ram_code, code_err, bit_alarma
    );

    // Requester / environment side.
    modport master (
        output req0, wr0, addr0, code0, req1, wr1, addr1, code1, frame_tick, alarm_on,
        input  gnt0, gnt1, ram_we, ram_addr, ram_code, code_err, bit_alarma
    );

endinterface

// File: rtl/char_buffer_arbiter_blink_gen.sv
// Frame-synchronous blink mask: toggles phase every BLINK_FRAMES frame ticks.
module blink_gen #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_frame_tick,
    input  logic i_alarm_on,
    output logic o_bit_alarma
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] r_blink_cnt;
    logic             r_blink_phase;
    logic             r_bit_alarma;

    // Count frames, flip phase each half-period, and gate the mask by alarm_on.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_bit_alarma  <= 1'b0;
        end else begin
            if (i_frame_tick) begin
                if (r_blink_cnt == CNT_LAST) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + CNT_W'(1);
                end
            end
            r_bit_alarma <= i_alarm_on & r_blink_phase;
        end
    end

    assign o_bit_alarma = r_bit_alarma;

endmodule

// File: rtl/char_buffer_arbiter.sv
// Two-writer round-robin arbiter for the character buffer write port, with
// bounded bursts, glyph range check, registered RAM write and blink generation.
module char_buffer_arbiter
    import char_buffer_pkg::*;
#(
    parameter int MAX_BURST    = 16,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                  reloj,
    input  logic                  resetM,
    char_buffer_arbiter_if.slave  bus
);

    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0] BURST_MAX = BC_W'(MAX_BURST);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              r_last;
    logic [BC_W-1:0]   r_burst_cnt;
    logic [BC_W-1:0]   w_burst_next;

    logic              w_own_req;
    logic              w_own_wr;
    logic              w_other_req;

    logic [1:0]        w_req;
    logic [1:0]        w_wr;
    logic [1:0]        w_gnt;
    logic [1:0]        w_wr_acc;
    logic              w_wr_any;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [CODE_W-1:0] w_sel_code;

    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [CODE_W-1:0] r_ram_code;
    logic              r_code_err;

    assign w_req = {bus.req1, bus.req0};
    assign w_wr  = {bus.wr1,  bus.wr0};

    // Pick the current owner's request/strobe and the competitor's request.
    always_comb begin
        w_own_req   = 1'b0;
        w_own_wr    = 1'b0;
        w_other_req = 1'b0;
        case (r_state)
            ST_OWN0: begin
                w_own_req   = bus.req0;
                w_own_wr    = bus.wr0;
                w_other_req = bus.req1;
            end
            ST_OWN1: begin
                w_own_req   = bus.req1;
                w_own_wr    = bus.wr1;
                w_other_req = bus.req0;
            end
            default: ;
        endcase
    end

    // Burst count after this cycle's write, saturating so a lone owner keeps its grant.
    always_comb begin
        w_burst_next = r_burst_cnt;
        if (w_own_wr && (r_burst_cnt != BURST_MAX))
            w_burst_next = r_burst_cnt + BC_W'(1);
    end

    // Next-state: round-robin from IDLE, release on drop or on exhausted burst under contention.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req0 && bus.req1)
                    w_state_next = r_last ? ST_OWN0 : ST_OWN1;
                else if (bus.req0)
                    w_state_next = ST_OWN0;
                else if (bus.req1)
                    w_state_next = ST_OWN1;
            end
            ST_OWN0, ST_OWN1: begin
                if (!w_own_req)
                    w_state_next = ST_IDLE;
                else if (w_other_req && (w_burst_next == BURST_MAX))
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register plus last-owner and burst bookkeeping.
    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b1;
            r_burst_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE) begin
                if (w_state_next != ST_IDLE) begin
                    r_last      <= (w_state_next == ST_OWN1);
                    r_burst_cnt <= '0;
                end
            end else if (w_own_req) begin
                r_burst_cnt <= w_burst_next;
            end
        end
    end

    // Grants decode straight from the state register, so they are glitch-free and exclusive.
    always_comb begin
        w_gnt[0] = (r_state == ST_OWN0);
        w_gnt[1] = (r_state == ST_OWN1);
    end

    // A write is accepted only from the granted requester while it still requests.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_acc
            assign w_wr_acc[gi] = w_gnt[gi] & w_req[gi] & w_wr[gi];
        end
    endgenerate

    assign w_wr_any   = |w_wr_acc;
    assign w_sel_addr = w_wr_acc[1] ? bus.addr1 : bus.addr0;
    assign w_sel_code = w_wr_acc[1] ? bus.code1 : bus.code0;

    // Registered RAM write; bad glyph codes become blank and latch the error flag.
    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_code <= '0;
            r_code_err <= 1'b0;
        end else if (w_wr_any) begin
            r_ram_we   <= 1'b1;
            r_ram_addr <= w_sel_addr;
            if (code_valid(w_sel_code)) begin
                r_ram_code <= w_sel_code;
            end else begin
                r_ram_code <= GLYPH_BLANK;
                r_code_err <= 1'b1;
            end
        end else begin
            r_ram_we <= 1'b0;
        end
    end

    blink_gen #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink_gen (
        .i_clk        (reloj),
        .i_rst_n      (resetM),
        .i_frame_tick (bus.frame_tick),
        .i_alarm_on   (bus.alarm_on),
        .o_bit_alarma (bus.bit_alarma)
    );

    assign bus.gnt0     = w_gnt[0];
    assign bus.gnt1     = w_gnt[1];
    assign bus.ram_we   = r_ram_we;
    assign bus.ram_addr = r_ram_addr;
    assign bus.ram_code = r_ram_code;
    assign bus.code_err = r_code_err;

endmodule

// File: tb/tb_char_buffer_arbiter.sv
// Directed bench for char_buffer_arbiter: grants, round-robin, bursts, code check, blink, async reset.
module tb_char_buffer_arbiter;
    import char_buffer_pkg::*;

    logic reloj  = 1'b0;
    logic resetM = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 reloj = ~reloj;

    char_buffer_arbiter_if bus_if ();

    char_buffer_arbiter #(
        .MAX_BURST    (16),
        .BLINK_FRAMES (2)
    ) dut (
        .reloj  (reloj),
        .resetM (resetM),
        .bus    (bus_if)
    );

    task automatic idle_inputs();
        bus_if.req0 = 1'b0; bus_if.wr0 = 1'b0; bus_if.addr0 = '0; bus_if.code0 = '0;
        bus_if.req1 = 1'b0; bus_if.wr1 = 1'b0; bus_if.addr1 = '0; bus_if.code1 = '0;
        bus_if.frame_tick = 1'b0; bus_if.alarm_on = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        @(negedge reloj);
        resetM = 1'b0;
        repeat (2) @(negedge reloj);
        resetM = 1'b1;
    endtask

    task automatic test_reset();
        logic [4:0] flags;
        idle_inputs();
        resetM = 1'b0;
        repeat (2) @(negedge reloj);
        flags = {bus_if.gnt0, bus_if.gnt1, bus_if.ram_we, bus_if.code_err, bus_if.bit_alarma};
        $display("reset: flags=%b addr=%0d code=%h", flags, bus_if.ram_addr, bus_if.ram_code);
        checks++;
        if (flags !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", flags); end
        checks++;
        if (bus_if.ram_addr !== 13'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", bus_if.ram_addr); end
        checks++;
        if (bus_if.ram_code !== 6'h00) begin failures++; $display("FAIL reset_code got=%h exp=00", bus_if.ram_code); end
        resetM = 1'b1;
    endtask

    task automatic test_single_write();
        apply_reset();
        bus_if.req0 = 1'b1; bus_if.wr0 = 1'b1; bus_if.addr0 = 13'd85; bus_if.code0 = 6'h01;
        repeat (2) @(negedge reloj);
        checks++;
        if (bus_if.gnt0 !== 1'b1 || bus_if.gnt1 !== 1'b0) begin
            failures++; $display("FAIL single_gnt got=%b%b exp=10", bus_if.gnt0, bus_if.gnt1);
        end
        @(negedge reloj);
        $display("single: we=%0b addr=%0d code=%h", bus_if.ram_we, bus_if.ram_addr, bus_if.ram_code);
        checks++;
        if (bus_if.ram_we !== 1'b1 || bus_if.ram_addr !== 13'd85 || bus_if.ram_code !== 6'h01) begin
            failures++;
            $display("FAIL single_write got=%0b/%0d/%h exp=1/85/01", bus_if.ram_we, bus_if.ram_addr, bus_if.ram_code);
        end
        // Dropping req0 with wr0 still high: that write must be ignored.
        bus_if.req0 = 1'b0; bus_if.addr0 = 13'd200; bus_if.code0 = 6'h02;
        @(negedge reloj);
        $display("drop: gnt0=%0b we=%0b addr=%0d", bus_if.gnt0, bus_if.ram_we, bus_if.ram_addr);
        checks++;
        if (bus_if.gnt0 !== 1'b0 || bus_if.ram_we !== 1'b0 || bus_if.ram_addr !== 13'd85) begin
            failures++;
            $display("FAIL drop_ignored got=%0b/%0b/%0d exp=0/0/85", bus_if.gnt0, bus_if.ram_we, bus_if.ram_addr);
        end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        apply_reset();
        bus_if.req0 = 1'b1; bus_if.req1 = 1'b1;
        @(negedge reloj);
        $display("rr: both -> gnt=%b%b", bus_if.gnt0, bus_if.gnt1);
        checks++;
        if ({bus_if.gnt0, bus_if.gnt1} !== 2'b10) begin failures++; $display("FAIL rr_first got=%b%b exp=10", bus_if.gnt0, bus_if.gnt1); end
        bus_if.req0 = 1'b0;
        @(negedge reloj);
        checks++;
        if ({bus_if.gnt0, bus_if.gnt1} !== 2'b00) begin failures++; $display("FAIL rr_idle got=%b%b exp=00", bus_if.gnt0, bus_if.gnt1); end
        @(negedge reloj);
        $display("rr: drop0 -> gnt=%b%b", bus_if.gnt0, bus_if.gnt1);
        checks++;
        if ({bus_if.gnt0, bus_if.gnt1} !== 2'b01) begin failures++; $display("FAIL rr_second got=%b%b exp=01", bus_if.gnt0, bus_if.gnt1); end
        bus_if.req1 = 1'b0;
        @(negedge reloj);
        bus_if.req0 = 1'b1; bus_if.req1 = 1'b1;
        @(negedge reloj);
        $display("rr: both again -> gnt=%b%b", bus_if.gnt0, bus_if.gnt1);
        checks++;
        if ({bus_if.gnt0, bus_if.gnt1} !== 2'b10) begin failures++; $display("FAIL rr_third got=%b%b exp=10", bus_if.gnt0, bus_if.gnt1); end
        idle_inputs();
    endtask

    task automatic test_burst();
        int we_cnt = 0;
        int g0_cnt = 0;
        int overlap = 0;
        int fall_at = -1;
        int g1_at = -1;
        apply_reset();
        bus_if.req0 = 1'b1; bus_if.req1 = 1'b1; bus_if.wr0 = 1'b1;
        bus_if.addr0 = 13'd300; bus_if.code0 = 6'h05;
        for (int c = 1; c <= 40; c++) begin
            @(negedge reloj);
            if (bus_if.ram_we) we_cnt++;
            if (bus_if.gnt0) g0_cnt++;
            if (bus_if.gnt0 && bus_if.gnt1) overlap++;
            if (fall_at < 0 && g0_cnt > 0 && !bus_if.gnt0) fall_at = c;
            if (g1_at < 0 && bus_if.gnt1) g1_at = c;
        end
        $display("burst: we=%0d gnt0_cycles=%0d fall=%0d gnt1_at=%0d", we_cnt, g0_cnt, fall_at, g1_at);
        checks++;
        if (we_cnt != 16) begin failures++; $display("FAIL burst_we_count got=%0d exp=16", we_cnt); end
        checks++;
        if (g0_cnt != 16) begin failures++; $display("FAIL burst_gnt0_cycles got=%0d exp=16", g0_cnt); end
        checks++;
        if (fall_at != 17 || g1_at != 18) begin
            failures++; $display("FAIL burst_handover got=%0d/%0d exp=17/18", fall_at, g1_at);
        end
        checks++;
        if (overlap != 0) begin failures++; $display("FAIL burst_overlap got=%0d exp=0", overlap); end
        idle_inputs();
    endtask

    task automatic test_code_err();
        apply_reset();
        bus_if.req1 = 1'b1; bus_if.wr1 = 1'b1; bus_if.addr1 = 13'd100; bus_if.code1 = 6'h2B;
        repeat (2) @(negedge reloj);
        $display("code: 2B -> code=%h err=%0b", bus_if.ram_code, bus_if.code_err);
        checks++;
        if (bus_if.ram_we !== 1'b1 || bus_if.ram_code !== 6'h2B || bus_if.code_err !== 1'b0) begin
            failures++; $display("FAIL code_max got=%0b/%h/%0b exp=1/2b/0", bus_if.ram_we, bus_if.ram_code, bus_if.code_err);
        end
        bus_if.addr1 = 13'd101; bus_if.code1 = 6'h2C;
        @(negedge reloj);
        $display("code: 2C -> code=%h err=%0b", bus_if.ram_code, bus_if.code_err);
        checks++;
        if (bus_if.ram_we !== 1'b1 || bus_if.ram_addr !== 13'd101 || bus_if.ram_code !== 6'h00 || bus_if.code_err !== 1'b1) begin
            failures++;
            $display("FAIL code_over got=%0b/%0d/%h/%0b exp=1/101/00/1", bus_if.ram_we, bus_if.ram_addr, bus_if.ram_code, bus_if.code_err);
        end
        bus_if.addr1 = 13'd102; bus_if.code1 = 6'h3F;
        @(negedge reloj);
        checks++;
        if (bus_if.ram_code !== 6'h00 || bus_if.code_err !== 1'b1) begin
            failures++; $display("FAIL code_3f got=%h/%0b exp=00/1", bus_if.ram_code, bus_if.code_err);
        end
        bus_if.addr1 = 13'd4900; bus_if.code1 = 6'h05;
        @(negedge reloj);
        $display("code: 05 -> addr=%0d code=%h err=%0b", bus_if.ram_addr, bus_if.ram_code, bus_if.code_err);
        checks++;
        if (bus_if.ram_addr !== 13'd4900 || bus_if.ram_code !== 6'h05 || bus_if.code_err !== 1'b1) begin
            failures++; $display("FAIL code_sticky got=%0d/%h/%0b exp=4900/05/1", bus_if.ram_addr, bus_if.ram_code, bus_if.code_err);
        end
        bus_if.wr1 = 1'b0;
        @(negedge reloj);
        checks++;
        if (bus_if.ram_we !== 1'b0 || bus_if.ram_code !== 6'h05 || bus_if.ram_addr !== 13'd4900) begin
            failures++; $display("FAIL code_hold got=%0b/%h/%0d exp=0/05/4900", bus_if.ram_we, bus_if.ram_code, bus_if.ram_addr);
        end
        idle_inputs();
        resetM = 1'b0;
        @(negedge reloj);
        checks++;
        if (bus_if.code_err !== 1'b0) begin failures++; $display("FAIL code_err_clear got=%0b exp=0", bus_if.code_err); end
        resetM = 1'b1;
    endtask

    task automatic test_blink();
        logic [5:0] exp_tab;
        exp_tab = 6'b100110;
        apply_reset();
        bus_if.alarm_on = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge reloj);
            bus_if.frame_tick = 1'b1;
            @(negedge reloj);
            bus_if.frame_tick = 1'b0;
            repeat (8) @(negedge reloj);
            $display("blink: tick %0d -> bit_alarma=%0b", i + 1, bus_if.bit_alarma);
            checks++;
            if (bus_if.bit_alarma !== exp_tab[i]) begin
                failures++; $display("FAIL blink_tick%0d got=%0b exp=%0b", i + 1, bus_if.bit_alarma, exp_tab[i]);
            end
        end
        bus_if.alarm_on = 1'b0;
        @(negedge reloj);
        checks++;
        if (bus_if.bit_alarma !== 1'b0) begin failures++; $display("FAIL blink_off got=%0b exp=0", bus_if.bit_alarma); end
        bus_if.alarm_on = 1'b1;
        @(negedge reloj);
        checks++;
        if (bus_if.bit_alarma !== 1'b1) begin failures++; $display("FAIL blink_on_again got=%0b exp=1", bus_if.bit_alarma); end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus_if.req1 = 1'b1; bus_if.wr1 = 1'b1; bus_if.addr1 = 13'd7; bus_if.code1 = 6'h03;
        repeat (3) @(negedge reloj);
        checks++;
        if (bus_if.gnt1 !== 1'b1 || bus_if.ram_we !== 1'b1) begin
            failures++; $display("FAIL areset_pre got=%0b/%0b exp=1/1", bus_if.gnt1, bus_if.ram_we);
        end
        #2 resetM = 1'b0;
        #1;
        $display("areset: gnt1=%0b we=%0b addr=%0d", bus_if.gnt1, bus_if.ram_we, bus_if.ram_addr);
        checks++;
        if (bus_if.gnt1 !== 1'b0 || bus_if.ram_we !== 1'b0 || bus_if.ram_addr !== 13'd0) begin
            failures++; $display("FAIL areset_now got=%0b/%0b/%0d exp=0/0/0", bus_if.gnt1, bus_if.ram_we, bus_if.ram_addr);
        end
        bus_if.wr1 = 1'b0; bus_if.req0 = 1'b1;
        @(negedge reloj);
        resetM = 1'b1;
        #1;
        checks++;
        if ({bus_if.gnt0, bus_if.gnt1} !== 2'b00) begin failures++; $display("FAIL areset_idle got=%b%b exp=00", bus_if.gnt0, bus_if.gnt1); end
        @(negedge reloj);
        $display("areset: after release gnt=%b%b", bus_if.gnt0, bus_if.gnt1);
        checks++;
        if ({bus_if.gnt0, bus_if.gnt1} !== 2'b10) begin failures++; $display("FAIL areset_last got=%b%b exp=10", bus_if.gnt0, bus_if.gnt1); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_round_robin();
        test_burst();
        test_code_err();
        test_blink();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/char_buffer_arbiter.md
Name: char_buffer_arbiter

Overview:
- Shares the single write port of the text character buffer (80x60 cells, one 6-bit glyph code per cell) between two writers.
- Requester 0 is the time/date updater; requester 1 is the menu/alarm text writer.
- Performs round-robin arbitration with bounded bursts, range-checks glyph codes, and registers the RAM write.
- Also generates the frame-synchronous blink signal bit_alarma consumed by the glyph pixel stage.

Parameters:
ADDR_W, 13, character buffer address width (cells 0..4799)
CODE_W, 6, glyph code width
MAX_CODE, 6'h2B, highest valid glyph code (arrow right)
MAX_BURST, 16, maximum writes per grant while the other requester waits
BLINK_FRAMES, 30, frames per blink half-period

Ports:
reloj  in  1  system pixel clock
resetM  in  1  asynchronous reset, active-low
req0  in  1  requester 0 wants the buffer
wr0  in  1  requester 0 write strobe, valid only while gnt0=1
addr0  in  ADDR_W  requester 0 cell address
code0  in  CODE_W  requester 0 glyph code
gnt0  out  1  requester 0 owns the write port
req1  in  1  requester 1 wants the buffer
wr1  in  1  requester 1 write strobe, valid only while gnt1=1
addr1  in  ADDR_W  requester 1 cell address
code1  in  CODE_W  requester 1 glyph code
gnt1  out  1  requester 1 owns the write port
ram_we  out  1  registered write enable to the character buffer
ram_addr  out  ADDR_W  registered write address
ram_code  out  CODE_W  registered write data
code_err  out  1  sticky flag: an out-of-range code was written
frame_tick  in  1  one-cycle pulse at start of vertical blank
alarm_on  in  1  alarm text should blink
bit_alarma  out  1  blink mask; 1 = suppress glyph pixels

Behaviour:
- Reset (resetM=0, asynchronous): state IDLE; gnt0=gnt1=0; ram_we=0; ram_addr=0; ram_code=0; code_err=0; last=1 (so requester 0 wins first); burst_cnt=0; blink_cnt=0; blink_phase=0; bit_alarma=0. Reset mid-transfer drops the grant immediately; a pending ram_we is lost.
- States: IDLE, OWN0, OWN1; gnt0 = (state==OWN0), gnt1 = (state==OWN1), both registered.
- IDLE: if only one req is high, go to that OWNx. If both are high, go to OWN(1-last). Otherwise stay in IDLE.
- Entering OWNx: last<=x, burst_cnt<=0.
- OWNx, while reqx=1:
  - each wrx=1 cycle increments burst_cnt.
  - When burst_cnt reaches MAX_BURST and the other req=1, go to IDLE; the next cycle grants the other requester.
  - When the other req=0, burst_cnt saturates at MAX_BURST and the grant is held.
- OWNx, reqx=0: go to IDLE. A wrx on that same cycle is ignored.
- One IDLE cycle always separates grants; gnt0 and gnt1 are never both 1.
- Write path, latency 1 cycle:
  - When gntx=1 and wrx=1 (sampled with the current registered grant), ram_we<=1, ram_addr<=addrx, ram_code<=codex.
  - If codex>MAX_CODE, ram_code<=0 (blank) and code_err<=1. code_err is cleared only by reset.
  - Otherwise ram_we<=0; ram_addr and ram_code hold their values.
  - wrx without gntx is dropped silently.
  - Addresses >=4800 are passed through unchanged; the RAM ignores them.
- Blink:
  - On frame_tick: if blink_cnt==BLINK_FRAMES-1, then blink_cnt<=0 and blink_phase toggles; else blink_cnt increments.
  - bit_alarma <= alarm_on & blink_phase, registered.
  - alarm_on falling forces bit_alarma=0 on the next cycle. The counter keeps running.

Decomposition:
- Shared package (char_buffer_pkg):
  - constants TEXT_COLS=80, TEXT_ROWS=60, ADDR_W, CODE_W.
  - glyph code constants GLYPH_BLANK=6'h00, GLYPH_A=6'h27, GLYPH_ARROW_UP=6'h28 through GLYPH_ARROW_RIGHT=6'h2B, MAX_CODE.
  - arbiter state encoding typedef.
- Sub-module blink_gen holds frame_tick, blink_cnt, blink_phase and bit_alarma, parameterised by BLINK_FRAMES. The arbiter FSM and write path stay in the top module.

Test Plan:
- Reset then req0=1, wr0=1, addr0=13'd85, code0=6'h01 -> gnt0=1 two cycles after req0 rises; next cycle ram_we=1, ram_addr=85, ram_code=6'h01.
- req0 and req1 rise together from reset -> gnt0 first. Drop req0 -> IDLE for 1 cycle, then gnt1=1. Raise both again -> gnt0 (round-robin).
- Both requesting, requester 0 writing every cycle with MAX_BURST=16 -> exactly 16 ram_we pulses from requester 0, one IDLE cycle, then gnt1=1.
- Requester 1 writes code 6'h3F -> ram_code=6'h00, ram_we=1, code_err=1. code_err stays 1 after later valid writes and clears only on resetM=0.
- alarm_on=1, frame_tick every 10 cycles, BLINK_FRAMES=2 -> bit_alarma alternates 0/1 every 2 ticks. alarm_on=0 -> bit_alarma=0 the next cycle.
- resetM pulsed low while gnt1=1 and wr1=1 -> gnt1=0 and ram_we=0 immediately (asynchronous). After release, the arbiter is in IDLE with last=1.
